// File: rtl/exp_iter_core.sv
// exp_iter_core: e^x by shift-add multiplicative normalisation, Q4.11 in, Q16.16 out.
// Optional EXP_ITER_RESIDUAL_EN exposes the final residual r for accuracy checks.
module exp_iter_core #(
  parameter int ITER_N = 11,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [14:0]      data,
  input  logic [4:0]       i,
  input  logic             int_or_fra,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             ovf
`ifdef EXP_ITER_RESIDUAL_EN
  ,
  output logic [10:0]      residual
`endif
);
  typedef enum logic [2:0] {IDLE, PREP, ITER, SCALE, DONE} state_t;
  localparam logic [4:0] LAST = 5'(ITER_N);
  localparam logic [15:0] LN2 = 16'd1419;
  // ln(1+2^-j) in Q0.11, entry 0 unused
  localparam logic [11:0][9:0] LN_TAB = {10'd1, 10'd2, 10'd4, 10'd8, 10'd16, 10'd32,
                                         10'd63, 10'd124, 10'd241, 10'd457, 10'd830, 10'd0};
  state_t state, state_d;
  logic [14:0] d;
  logic [4:0] ic, k, j;
  logic mode;
  logic [15:0] r, d16, prod, tab;
  logic [17:0] y;
  logic [4:0] j0;
  logic [33:0] sh;
  assign d16 = {1'b0, d};
  assign prod = {11'b0, ic} * LN2;
  assign j0 = mode ? 5'd1 : (ic == 5'd0 ? 5'd1 : ic);
  assign tab = {6'b0, LN_TAB[j[3:0]]};
  assign sh = {16'b0, y} << k[3:0];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  state_d = in_valid ? PREP : IDLE;
      PREP:  state_d = j0 > LAST ? SCALE : ITER;
      ITER:  state_d = j == LAST ? SCALE : ITER;
      SCALE: state_d = DONE;
      DONE:  state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= '0;
      ic <= '0;
      mode <= 1'b0;
      k <= '0;
      r <= '0;
      j <= '0;
      y <= '0;
      result <= '0;
      ovf <= 1'b0;
`ifdef EXP_ITER_RESIDUAL_EN
      residual <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          d <= data;
          ic <= i;
          mode <= int_or_fra;
        end
        PREP: begin
          k <= mode ? ic : 5'd0;
          r <= mode ? (d16 < prod ? 16'd0 : d16 - prod) : d16;
          j <= j0;
          y <= 18'h10000;
        end
        ITER: begin
          if (r >= tab) begin
            r <= r - tab;
            y <= y + (y >> j);
          end
          j <= j + 5'd1;
        end
        SCALE: begin
          ovf <= k[4] | (|sh[33:32]);
          result <= (k[4] | (|sh[33:32])) ? {OUT_W{1'b1}} : OUT_W'(sh[31:0]);
`ifdef EXP_ITER_RESIDUAL_EN
          residual <= r[10:0];
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_exp_iter_core.sv
// tb_exp_iter_core: randomized self-checking bench for exp_iter_core against an arithmetic model.
module tb_exp_iter_core;
  localparam int ITER_N = 11;
  logic clk = 0, rst_n = 0, in_valid = 0, int_or_fra = 0, out_ready = 0;
  logic [14:0] data = '0;
  logic [4:0] i = '0;
  logic in_ready, out_valid, ovf;
  logic [31:0] result;
  int checks = 0, errors = 0;
  int tab [12] = '{0, 830, 457, 241, 124, 63, 32, 16, 8, 4, 2, 1};

  exp_iter_core #(.ITER_N(ITER_N), .OUT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .i(i), .int_or_fra(int_or_fra), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int dv, input int iv, input int mv,
                                output longint res, output bit ov, output int n);
    int k, r, j0;
    longint y;
    k = mv ? iv : 0;
    r = mv ? (dv >= k * 1419 ? dv - k * 1419 : 0) : dv;
    j0 = mv ? 1 : (iv < 1 ? 1 : iv);
    n = j0 > ITER_N ? 0 : ITER_N - j0 + 1;
    y = 65536;
    for (int j = j0; j <= ITER_N; j++)
      if (r >= tab[j]) begin
        r -= tab[j];
        y = y + y / (longint'(1) << j);
      end
    ov = (k >= 16) || ((y << k) >= (longint'(1) << 32));
    res = ov ? 64'hFFFF_FFFF : (y << k);
  endfunction

  task automatic run_op(input int dv, input int iv, input int mv, input int hold);
    longint er;
    bit eo;
    int n, lat;
    bit busy_rdy;
    logic [31:0] held;
    model(dv, iv, mv, er, eo, n);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    data = 15'(dv); i = 5'(iv); int_or_fra = mv[0]; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    busy_rdy = 0;
    while (!out_valid && lat < 200) begin
      busy_rdy |= in_ready;
      @(negedge clk);
      lat++;
    end
    check("in_ready_busy", busy_rdy, 0);
    check("latency", lat, n + 2);
    check("result", result, er);
    check("ovf", ovf, eo);
    held = result;
    repeat (hold) begin
      in_valid = 1;
      data = 15'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", result, held);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
  endtask

  initial begin
    int dv, iv, mv;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1;
    run_op(0, 1, 0, 0);
    run_op(1419, 1, 1, 0);
    run_op(830, 1, 0, 0);
    run_op(63, 5, 0, 0);
    run_op(100, 1, 1, 0);
    run_op(22704, 16, 1, 0);
    run_op(500, 12, 0, 0);
    run_op(21284, 15, 1, 5);
    for (int t = 0; t < 30; t++) begin
      mv = $urandom_range(0, 1);
      if (mv == 1) begin
        dv = $urandom_range(0, 32767);
        iv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : dv / 1419;
      end else begin
        dv = $urandom_range(0, 1418);
        iv = $urandom_range(0, 13);
      end
      run_op(dv, iv, mv, $urandom_range(0, 2));
    end
    @(negedge clk);
    data = 15'd1000; i = 5'd1; int_or_fra = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    run_op(1419, 2, 1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
